// File: rtl/btn_rst_ctrl.sv
// btn_rst_ctrl: synchronise, debounce and edge-detect button lines; stretch reset.
// Optional auto-repeat of held buttons is built when BTN_AUTOREPEAT_EN is defined.
module btn_rst_ctrl #(
    parameter int                  CHANNELS    = 4,
    parameter int                  DB_CYCLES   = 10000,
    parameter int                  RST_STRETCH = 16,
    parameter int                  REP_DELAY   = 5000000,
    parameter int                  REP_PERIOD  = 1000000,
    parameter logic [CHANNELS-1:0] REP_MASK    = {CHANNELS{1'b1}}
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] btn_raw,
    input  logic                rst_req,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic                rst_out
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    if ((CHANNELS < 1) || (DB_CYCLES < 1) || (RST_STRETCH < 1) ||
        (REP_DELAY < 1) || (REP_PERIOD < 1) ||
        ($bits(REP_MASK) != CHANNELS)) begin : g_bad_cfg
        $error("btn_rst_ctrl: invalid parameter set");
    end

    logic [CHANNELS-1:0]         b_s1;
    logic [CHANNELS-1:0]         b_s2;
    logic [CHANNELS-1:0][CW-1:0] db_cnt;
    logic [CHANNELS-1:0]         db_hit;
    logic [CHANNELS-1:0]         rise;
    logic [CHANNELS-1:0]         fall;
    logic [CHANNELS-1:0]         rep_fire;
    logic                        rq_s1;
    logic                        rq_s2;
    logic [RST_STRETCH-1:0]      rst_sr;
    logic                        rst_nxt;

    // next value of rst_out, so presses are masked in the same cycle
    assign rst_nxt = |rst_sr;

    // a channel toggles when it has differed for DB_CYCLES cycles
    always_comb begin
        db_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            db_hit[i] = (b_s2[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    assign rise = db_hit & ~btn_level;
    assign fall = db_hit & btn_level;

    // input synchronisers and the reset stretcher shift register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_s1    <= '0;
            b_s2    <= '0;
            rq_s1   <= 1'b0;
            rq_s2   <= 1'b0;
            rst_sr  <= '1;
            rst_out <= 1'b1;
        end else begin
            b_s1    <= btn_raw;
            b_s2    <= b_s1;
            rq_s1   <= rst_req;
            rq_s2   <= rq_s1;
            rst_sr  <= (rst_sr << 1) | RST_STRETCH'(rq_s2);
            rst_out <= rst_nxt;
        end
    end

    // debounce counters, debounced level and edge pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            db_cnt      <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ((b_s2[i] == btn_level[i]) || db_hit[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            btn_level   <= btn_level ^ db_hit;
            btn_press   <= (rise | rep_fire) & {CHANNELS{~rst_nxt}};
            btn_release <= fall;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_FIRST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] R_NEXT = RW'(REP_PERIOD - 1);

    logic [CHANNELS-1:0][RW-1:0] rep_cnt;

    // repeat fires when a held channel's countdown expires
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rep_fire[i] = REP_MASK[i] && btn_level[i] && !fall[i] &&
                          (rep_cnt[i] == '0);
        end
    end

    // countdown to the next repeat; keeps running under rst_out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_cnt <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!REP_MASK[i] || fall[i] || (!btn_level[i] && !rise[i])) begin
                    rep_cnt[i] <= '0;
                end else if (rise[i]) begin
                    rep_cnt[i] <= R_FIRST;
                end else if (rep_cnt[i] == '0) begin
                    rep_cnt[i] <= R_NEXT;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] - 1'b1;
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_btn_rst_ctrl.sv
// tb_btn_rst_ctrl: directed plus random stimulus for btn_rst_ctrl,
// checked each cycle against a sliding-window reference model.
module tb_btn_rst_ctrl;

    localparam int CH = 4;
    localparam int DB = 4;
    localparam int RS = 16;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam logic [CH-1:0] RM = 4'b0111;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [CH-1:0] btn_raw = '0;
    logic          rst_req = 1'b0;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] btn_press;
    logic [CH-1:0] btn_release;
    logic          rst_out;

    int tests = 0;
    int fails = 0;

    int            n;
    logic [CH-1:0] raw_h [0:4095];
    logic          req_h [0:4095];
    logic [CH-1:0] m_lvl;
    int            t_press [CH];

    btn_rst_ctrl #(
        .CHANNELS   (CH),
        .DB_CYCLES  (DB),
        .RST_STRETCH(RS),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP),
        .REP_MASK   (RM)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_raw    (btn_raw),
        .rst_req    (rst_req),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .rst_out    (rst_out)
    );

    always #5 clk = ~clk;

    function automatic logic [CH-1:0] raw_at(input int m);
        if (m < 1) return '0;
        return raw_h[m];
    endfunction

    task automatic model_reset();
        n = 0;
        m_lvl = '0;
        for (int c = 0; c < CH; c++) t_press[c] = 0;
    endtask

    task automatic chk(input string tag, input logic [CH-1:0] el,
                       input logic [CH-1:0] ep, input logic [CH-1:0] er,
                       input logic ers);
        tests++;
        assert (btn_level === el) else begin
            fails++;
            $error("FAIL %s level n=%0d got %b want %b", tag, n, btn_level, el);
        end
        tests++;
        assert (btn_press === ep) else begin
            fails++;
            $error("FAIL %s press n=%0d got %b want %b", tag, n, btn_press, ep);
        end
        tests++;
        assert (btn_release === er) else begin
            fails++;
            $error("FAIL %s release n=%0d got %b want %b", tag, n, btn_release, er);
        end
        tests++;
        assert (rst_out === ers) else begin
            fails++;
            $error("FAIL %s rst_out n=%0d got %b want %b", tag, n, rst_out, ers);
        end
    endtask

    // one clock: drive, advance the model on the edge, compare #1 later
    task automatic step(input string tag, input logic [CH-1:0] raw,
                        input logic req);
        logic [CH-1:0] e_p;
        logic [CH-1:0] e_r;
        logic [CH-1:0] s;
        logic          e_rst;
        bit            ok;
        int            age;
        btn_raw = raw;
        rst_req = req;
        @(posedge clk);
        e_p = '0;
        e_r = '0;
        if (!rstn) begin
            model_reset();
            e_rst = 1'b1;
        end else begin
            n++;
            raw_h[n] = raw;
            req_h[n] = req;
            e_rst = (n <= RS);
            for (int m = n - RS - 2; m <= n - 3; m++) begin
                if (m >= 1 && req_h[m]) e_rst = 1'b1;
            end
            for (int c = 0; c < CH; c++) begin
                ok = 1'b1;
                for (int m = n - DB - 1; m <= n - 2; m++) begin
                    s = raw_at(m);
                    if (s[c] == m_lvl[c]) ok = 1'b0;
                end
                age = n - t_press[c];
                if (ok) begin
                    m_lvl[c] = ~m_lvl[c];
                    if (m_lvl[c]) begin
                        e_p[c] = 1'b1;
                        t_press[c] = n;
                    end else begin
                        e_r[c] = 1'b1;
                    end
                end else if (AR && RM[c] && m_lvl[c] && age >= RD &&
                             ((age - RD) % RP) == 0) begin
                    e_p[c] = 1'b1;
                end
            end
            if (e_rst) e_p = '0;
        end
        #1;
        chk(tag, m_lvl, e_p, e_r, e_rst);
        @(negedge clk);
    endtask

    initial begin
        logic [CH-1:0] r;
        model_reset();

        repeat (3) step("reset", '0, 1'b0);
        rstn = 1'b1;
        repeat (20) step("release", '0, 1'b0);

        repeat (10) step("press1", 4'b0010, 1'b0);
        repeat (10) step("rel1", '0, 1'b0);

        repeat (3) step("bounce", 4'b0001, 1'b0);
        step("bounce", '0, 1'b0);
        repeat (3) step("bounce", 4'b0001, 1'b0);
        repeat (7) step("bounce", 4'b0001, 1'b0);
        repeat (8) step("bounce", '0, 1'b0);

        step("rstreq", '0, 1'b1);
        repeat (4) step("rstreq", '0, 1'b0);
        repeat (12) step("rstreq", 4'b0100, 1'b0);
        repeat (12) step("rstreq", '0, 1'b0);

        repeat (30) step("repeat", 4'b1001, 1'b0);
        repeat (8) step("repeat", '0, 1'b0);

        r = '0;
        repeat (600) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
            end
            step("random", r, ($urandom_range(0, 79) == 0));
        end
        repeat (30) step("settle", '0, 1'b0);

        repeat (4) step("abort", 4'b0100, 1'b0);
        rstn = 1'b0;
        #1;
        model_reset();
        chk("abort_async", '0, '0, '0, 1'b1);
        @(negedge clk);
        repeat (2) step("abort", 4'b0100, 1'b0);
        rstn = 1'b1;
        repeat (25) step("abort_hold", 4'b0100, 1'b0);
        repeat (20) step("abort_rel", '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
